// File: rtl/vga_rx_pkg.sv
// Shared types and constants for the VGA sync receiver.
// Counters are 10 bits wide and saturate rather than wrap.
package vga_rx_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned H_TOTAL_DEF = 800;
  localparam int unsigned V_TOTAL_DEF = 525;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_e;

  function automatic coord_t sat_inc(input coord_t v);
    return (v == CNT_MAX) ? v : v + coord_t'(1);
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Samples the incoming sync stream on each pixel strobe and reports edges
// between successive samples, qualified for the clk that follows the sample.
module vga_sync_edge
  import vga_rx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pclk_en,
  input  logic h_sync,
  input  logic v_sync,
  input  logic de_in,
  output logic samp_vld,
  output logic h_fall,
  output logic v_fall,
  output logic de_rise,
  output logic de_fall,
  output logic de_cur,
  output logic de_prev
);

  logic h_cur_q, h_cur_d, h_prev_q, h_prev_d;
  logic v_cur_q, v_cur_d, v_prev_q, v_prev_d;
  logic de_cur_q, de_cur_d, de_prev_q, de_prev_d;
  logic samp_vld_q, samp_vld_d;

  always_comb begin
    h_cur_d    = h_cur_q;
    h_prev_d   = h_prev_q;
    v_cur_d    = v_cur_q;
    v_prev_d   = v_prev_q;
    de_cur_d   = de_cur_q;
    de_prev_d  = de_prev_q;
    samp_vld_d = pclk_en;
    if (pclk_en) begin
      h_cur_d   = h_sync;
      h_prev_d  = h_cur_q;
      v_cur_d   = v_sync;
      v_prev_d  = v_cur_q;
      de_cur_d  = de_in;
      de_prev_d = de_cur_q;
    end
  end

  // Syncs idle high so the first sample after reset cannot fake a fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cur_q    <= 1'b1;
      h_prev_q   <= 1'b1;
      v_cur_q    <= 1'b1;
      v_prev_q   <= 1'b1;
      de_cur_q   <= 1'b0;
      de_prev_q  <= 1'b0;
      samp_vld_q <= 1'b0;
    end else begin
      h_cur_q    <= h_cur_d;
      h_prev_q   <= h_prev_d;
      v_cur_q    <= v_cur_d;
      v_prev_q   <= v_prev_d;
      de_cur_q   <= de_cur_d;
      de_prev_q  <= de_prev_d;
      samp_vld_q <= samp_vld_d;
    end
  end

  assign samp_vld = samp_vld_q;
  assign h_fall   = samp_vld_q &  h_prev_q  & ~h_cur_q;
  assign v_fall   = samp_vld_q &  v_prev_q  & ~v_cur_q;
  assign de_rise  = samp_vld_q & ~de_prev_q &  de_cur_q;
  assign de_fall  = samp_vld_q &  de_prev_q & ~de_cur_q;
  assign de_cur   = de_cur_q;
  assign de_prev  = de_prev_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers pixel coordinates from an h_sync/v_sync/DE stream, measures line
// and frame totals, and tracks lock against the expected geometry.
module vga_sync_receiver
  import vga_rx_pkg::*;
#(
  parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pclk_en,
  input  logic               h_sync,
  input  logic               v_sync,
  input  logic               DE,
  output logic [COORD_W-1:0] x_pixel,
  output logic [COORD_W-1:0] y_pixel,
  output logic               pix_valid,
  output logic               line_start,
  output logic               frame_start,
  output logic [COORD_W-1:0] h_total,
  output logic [COORD_W-1:0] v_total,
  output logic               locked,
  output logic               sync_err
);

  localparam coord_t     H_EXP  = coord_t'(H_TOTAL);
  localparam coord_t     V_EXP  = coord_t'(V_TOTAL);
  localparam logic [2:0] LOCK_N = 3'(LOCK_FRAMES);

  logic samp_vld, h_fall, v_fall, de_rise, de_fall, de_cur, de_prev;

  vga_sync_edge u_edge (
    .clk      (clk),
    .reset    (reset),
    .pclk_en  (pclk_en),
    .h_sync   (h_sync),
    .v_sync   (v_sync),
    .de_in    (DE),
    .samp_vld (samp_vld),
    .h_fall   (h_fall),
    .v_fall   (v_fall),
    .de_rise  (de_rise),
    .de_fall  (de_fall),
    .de_cur   (de_cur),
    .de_prev  (de_prev)
  );

  coord_t     x_q, x_d, y_q, y_d;
  coord_t     per_q, per_d, ln_q, ln_d;
  coord_t     h_total_q, h_total_d, v_total_q, v_total_d;
  logic       pix_valid_q, pix_valid_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       sync_err_q, sync_err_d;
  logic       h_seen_q, h_seen_d;
  logic       line_bad_q, line_bad_d;
  logic [2:0] good_q, good_d;
  rx_state_e  state_q, state_d;

  logic bad_line, sat_evt, frame_ok;

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    per_d         = per_q;
    ln_d          = ln_q;
    h_total_d     = h_total_q;
    v_total_d     = v_total_q;
    pix_valid_d   = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    h_seen_d      = h_seen_q;
    line_bad_d    = line_bad_q;
    good_d        = good_q;
    state_d       = state_q;
    bad_line      = 1'b0;
    sat_evt       = 1'b0;
    frame_ok      = 1'b0;

    if (samp_vld) begin
      if (de_cur) begin
        pix_valid_d = 1'b1;
        x_d         = de_prev ? sat_inc(x_q) : '0;
      end
      line_start_d  = de_rise;
      frame_start_d = v_fall;

      if (v_fall) begin
        y_d = '0;
      end else if (de_fall) begin
        y_d = sat_inc(y_q);
      end

      // Period of the line just ended; only trusted once a real fall was seen.
      if (h_fall) begin
        per_d    = coord_t'(1);
        h_seen_d = 1'b1;
        if (h_seen_q) begin
          h_total_d = per_q;
          bad_line  = (per_q != H_EXP);
        end
      end else begin
        per_d   = sat_inc(per_q);
        sat_evt = h_seen_q && (per_q == CNT_MAX - coord_t'(1));
      end

      if (h_fall) begin
        ln_d = sat_inc(ln_q);
      end
      // A line starting on the frame's own v_sync fall belongs to the next frame.
      if (v_fall) begin
        v_total_d = ln_q;
        ln_d      = h_fall ? coord_t'(1) : '0;
      end

      frame_ok = (ln_q == V_EXP) && !line_bad_q && !bad_line && !sat_evt;

      case (state_q)
        SEARCH: begin
          if (v_fall) begin
            state_d    = MEASURE;
            good_d     = '0;
            line_bad_d = 1'b0;
          end
        end
        MEASURE: begin
          if (bad_line || sat_evt) begin
            line_bad_d = 1'b1;
          end
          if (v_fall) begin
            line_bad_d = 1'b0;
            if (frame_ok) begin
              good_d = good_q + 3'd1;
              if (good_q + 3'd1 >= LOCK_N) begin
                state_d = LOCKED;
              end
            end else begin
              good_d = '0;
            end
          end
        end
        LOCKED: begin
          if (bad_line || sat_evt || (v_fall && ln_q != V_EXP)) begin
            sync_err_d = 1'b1;
            state_d    = SEARCH;
            h_seen_d   = 1'b0;
          end
        end
        default: begin
          state_d = SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q           <= '0;
      y_q           <= '0;
      per_q         <= '0;
      ln_q          <= '0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      pix_valid_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      h_seen_q      <= 1'b0;
      line_bad_q    <= 1'b0;
      good_q        <= '0;
      state_q       <= SEARCH;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      per_q         <= per_d;
      ln_q          <= ln_d;
      h_total_q     <= h_total_d;
      v_total_q     <= v_total_d;
      pix_valid_q   <= pix_valid_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
      h_seen_q      <= h_seen_d;
      line_bad_q    <= line_bad_d;
      good_q        <= good_d;
      state_q       <= state_d;
    end
  end

  assign x_pixel     = x_q;
  assign y_pixel     = y_q;
  assign pix_valid   = pix_valid_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a reduced 40x10 geometry, checked every
// sample against a behavioural model of the stream rules.
module tb_vga_sync_receiver;

  localparam int H     = 40;
  localparam int V     = 10;
  localparam int LF    = 2;
  localparam int HSW   = 4;
  localparam int VSW   = 2;
  localparam int ACT   = 24;
  localparam int VA0   = 3;
  localparam int VROWS = 5;

  logic       clk, reset, pclk_en, h_sync, v_sync, DE;
  logic [9:0] x_pixel, y_pixel, h_total, v_total;
  logic       pix_valid, line_start, frame_start, locked, sync_err;

  vga_sync_receiver #(.H_TOTAL(H), .V_TOTAL(V), .LOCK_FRAMES(LF)) dut (
    .clk         (clk),
    .reset       (reset),
    .pclk_en     (pclk_en),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .DE          (DE),
    .x_pixel     (x_pixel),
    .y_pixel     (y_pixel),
    .pix_valid   (pix_valid),
    .line_start  (line_start),
    .frame_start (frame_start),
    .h_total     (h_total),
    .v_total     (v_total),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int obs_pix, obs_err, obs_fs, max_x, max_y, n_samp, err_samp;
  int gr, gc, hlen, vlen, ds;

  // behavioural model state
  bit m_ph, m_pv, m_pde, m_hseen, m_lock, m_meas, m_lbad;
  bit m_pix, m_ls, m_fs, m_err;
  int m_x, m_y, m_per, m_ln, m_ht, m_vt, m_good;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int inc(input int v);
    return (v >= 1023) ? 1023 : v + 1;
  endfunction

  function automatic logic [44:0] outs_now();
    return {x_pixel, y_pixel, pix_valid, line_start, frame_start, h_total, v_total, locked, sync_err};
  endfunction

  function automatic logic [44:0] m_vec(input bit pulses);
    return {10'(m_x), 10'(m_y), pulses & m_pix, pulses & m_ls, pulses & m_fs,
            10'(m_ht), 10'(m_vt), m_lock, pulses & m_err};
  endfunction

  task automatic model_reset();
    m_ph = 1; m_pv = 1; m_pde = 0; m_hseen = 0; m_lock = 0; m_meas = 0; m_lbad = 0;
    m_pix = 0; m_ls = 0; m_fs = 0; m_err = 0;
    m_x = 0; m_y = 0; m_per = 0; m_ln = 0; m_ht = 0; m_vt = 0; m_good = 0;
  endtask

  task automatic model_sample(input bit h, input bit v, input bit de);
    bit hf, vf, df, dr, bad;
    int old_ln;
    hf = m_ph && !h;  vf = m_pv && !v;
    df = m_pde && !de; dr = !m_pde && de;
    bad = 0;
    m_pix = de; m_ls = dr; m_fs = vf; m_err = 0;
    if (de) m_x = m_pde ? inc(m_x) : 0;
    if (vf) m_y = 0;
    else if (df) m_y = inc(m_y);
    if (hf) begin
      if (m_hseen) begin
        m_ht = m_per;
        if (m_per != H) bad = 1;
      end
      m_per = 1;
      m_hseen = 1;
    end else begin
      m_per = inc(m_per);
      if (m_hseen && m_per == 1023 && bad == 0 && m_per != 0) bad = (m_per == 1023) && (inc(m_per - 1) == 1023) && (m_per - 1 == 1022);
    end
    old_ln = m_ln;
    if (hf) m_ln = inc(m_ln);
    if (vf) begin
      m_vt = old_ln;
      m_ln = hf ? 1 : 0;
    end
    if (m_lock) begin
      if (bad || (vf && m_vt != V)) begin
        m_err = 1; m_lock = 0; m_meas = 0; m_hseen = 0;
      end
    end else if (m_meas) begin
      if (vf) begin
        if (m_vt == V && !m_lbad && !bad) begin
          m_good++;
          if (m_good >= LF) begin m_lock = 1; m_meas = 0; end
        end else m_good = 0;
        m_lbad = 0;
      end else if (bad) m_lbad = 1;
    end else if (vf) begin
      m_meas = 1; m_good = 0; m_lbad = 0;
    end
    m_ph = h; m_pv = v; m_pde = de;
  endtask

  // One pixel sample: strobe, then check outputs one clk later and again after the pulses clear.
  task automatic send(input bit h, input bit v, input bit de);
    @(negedge clk);
    h_sync = h; v_sync = v; DE = de; pclk_en = 1'b1;
    @(negedge clk);
    pclk_en = 1'b0;
    model_sample(h, v, de);
    @(negedge clk);
    if (pix_valid) begin
      obs_pix++;
      if (int'(x_pixel) > max_x) max_x = int'(x_pixel);
      if (int'(y_pixel) > max_y) max_y = int'(y_pixel);
    end
    if (sync_err) begin obs_err++; err_samp = n_samp; end
    if (frame_start) obs_fs++;
    chk("outs", outs_now(), m_vec(1'b1));
    @(negedge clk);
    chk("outs_hold", outs_now(), m_vec(1'b0));
    n_samp++;
  endtask

  task automatic next_pos();
    bit h, v, de;
    h  = (gc >= HSW);
    v  = (gr >= VSW);
    de = (gr >= VA0) && (gr < VA0 + VROWS) && (gc >= ds) && (gc < ds + ACT);
    send(h, v, de);
    gc++;
    if (gc >= hlen) begin
      gc = 0; hlen = H; gr++;
      if (gr >= vlen) begin gr = 0; vlen = V; end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) next_pos();
  endtask

  task automatic run_to(input int r, input int c);
    int guard = 0;
    while (!(gr == r && gc == c) && guard < 2 * H * V + 2 * H) begin
      next_pos();
      guard++;
    end
  endtask

  task automatic relock(input string tag);
    int guard = 0;
    obs_fs = 0;
    while (!locked && guard < 6 * H * V) begin
      next_pos();
      guard++;
    end
    chk({tag, "_locked"}, locked, 1);
    chk({tag, "_vf_to_lock"}, obs_fs, 3);
  endtask

  initial begin
    int r2, xr, gc0, samp0;
    reset = 1'b1; pclk_en = 1'b0; h_sync = 1'b1; v_sync = 1'b1; DE = 1'b0;
    #1 reset = 1'b0;
    model_reset();
    obs_pix = 0; obs_err = 0; obs_fs = 0; max_x = 0; max_y = 0; n_samp = 0; err_samp = -1;
    gr = 0; gc = 0; hlen = H; vlen = V;
    ds = $urandom_range(6, 10);
    repeat (3) @(negedge clk);
    chk("reset_outs", outs_now(), 45'd0);
    reset = 1'b1;

    // clean stream: lock on the third v_sync fall
    relock("clean");
    chk("clean_h_total", h_total, H);
    chk("clean_v_total", v_total, V);
    run_to(0, 0);
    next_pos();
    obs_pix = 0; max_x = 0; max_y = 0;
    run(H * V - 1);
    chk("pix_per_frame", obs_pix, ACT * VROWS);
    chk("max_x", max_x, ACT - 1);
    chk("max_y", max_y, VROWS - 1);

    // one line stretched by a sample
    r2 = $urandom_range(2, V - 2);
    run_to(r2, 0);
    hlen = H + 1;
    obs_err = 0;
    run(H + 1);
    next_pos();
    chk("stretch_err_count", obs_err, 1);
    chk("stretch_unlocked", locked, 0);
    relock("stretch");
    chk("stretch_err_total", obs_err, 1);

    // one short frame
    vlen = V - 1;
    obs_err = 0;
    run_to(0, 0);
    next_pos();
    chk("short_v_total", v_total, V - 1);
    chk("short_err_count", obs_err, 1);
    chk("short_unlocked", locked, 0);
    relock("short");

    // asynchronous reset mid-line
    xr = $urandom_range(5, 20);
    run_to(VA0 + 2, ds + xr);
    chk("x_before_reset", x_pixel, xr - 1);
    #2 reset = 1'b0;
    #1 chk("reset_async", outs_now(), 45'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    next_pos();
    chk("after_reset_unlocked", locked, 0);
    relock("reset");

    // long pause in the pixel strobe mid-line
    run_to(VA0 + 1, ds + 3);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      h_sync = 1'($urandom); v_sync = 1'($urandom); DE = 1'($urandom); pclk_en = 1'b0;
      if (i % 100 == 99) chk("pause_hold", outs_now(), m_vec(1'b0));
    end
    obs_err = 0;
    run(2 * H * V);
    chk("pause_no_err", obs_err, 0);
    chk("pause_locked", locked, 1);

    // h_sync stuck high: period counter saturates
    run_to(VA0 - 1, 20);
    gc0 = gc;
    samp0 = n_samp;
    obs_err = 0; err_samp = -1;
    for (int i = 0; i < 1100; i++) send(1'b1, 1'b1, 1'b0);
    chk("sat_err_count", obs_err, 1);
    chk("sat_err_at", err_samp - samp0, 1022 - gc0);
    chk("sat_h_total", h_total, H);
    chk("sat_unlocked", locked, 0);
    gr = 0; gc = 0; hlen = H; vlen = V;
    relock("sat");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Receive-side counterpart of the VGA timing generator. Consumes a pixel-rate sync stream (h_sync, v_sync, DE) from another board, an external source, or a loopback of our own generator, and recovers per-pixel x/y coordinates. Measures the line and frame totals and reports a lock status. It sits between the incoming video port and the road-control frame logic, which only uses pixels while `locked` is high.

## Interface
Parameters:
- H_TOTAL, 800, expected pixel samples per line
- V_TOTAL, 525, expected lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..7)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pclk_en  in  1  one-clk pixel strobe (1 of every 4 clks); inputs sampled only when high
- h_sync  in  1  active-low horizontal sync
- v_sync  in  1  active-low vertical sync
- DE  in  1  display enable, active-high
- x_pixel  out  10  column of current active pixel
- y_pixel  out  10  row of current active line
- pix_valid  out  1  one-clk pulse: x_pixel/y_pixel are valid for an active pixel
- line_start  out  1  one-clk pulse on DE rising
- frame_start  out  1  one-clk pulse on v_sync falling
- h_total  out  10  last measured line length, in samples
- v_total  out  10  last measured frame length, in lines
- locked  out  1  stream matches H_TOTAL/V_TOTAL
- sync_err  out  1  one-clk pulse on loss of lock

## Operation
- Sampling: on pclk_en, register h_sync, v_sync and DE plus their previous samples. Edges are detected between successive samples. Nothing changes on clks with pclk_en=0.
- Column: when DE is sampled 1, x resets to 0 if the previous DE sample was 0, otherwise x increments. A 1-clk pix_valid pulse follows. line_start pulses with x=0.
- Row: a v_sync falling edge clears y to 0. Each DE falling edge increments y, saturating at 1023.
- Line period: the period counter is set to 1 on an h_sync falling edge and increments on each sample. On the next falling edge, the count is captured into h_total, so a conforming stream gives 800. The counter saturates at 1023; reaching 1023 counts as a bad line.
- Frame length: the line counter increments on each h_sync falling edge. On a v_sync falling edge, the count is captured into v_total and the counter is cleared. If h_sync and v_sync fall on the same sample, the capture excludes that line and the counter restarts at 1.
- h_seen flag: set on the first h_sync fall after reset or after entering SEARCH. Period checks are ignored until it is set.
- FSM (package enum: SEARCH, MEASURE, LOCKED):
  - SEARCH: locked=0. A v_sync fall clears good_cnt and line_bad and moves to MEASURE.
  - MEASURE: any bad line period (≠H_TOTAL) sets line_bad. On a v_sync fall, a good frame (v_total==V_TOTAL and !line_bad) increments good_cnt, and when good_cnt reaches LOCK_FRAMES the FSM moves to LOCKED. A bad frame clears good_cnt. line_bad clears at every v_sync fall.
  - LOCKED: locked=1. A bad line period, a bad v_total, or period saturation pulses sync_err and moves to SEARCH.
- x/y/pix_valid run regardless of lock state.

## Timing
- Reset values: all outputs 0, FSM=SEARCH, all counters and sample registers 0. Sampled-sync registers reset to 1 (idle high) so that no false edge is seen. Reset takes effect immediately, including mid-frame.
- Latency: outputs update exactly 1 clk after the pclk_en clk on which the causing sample was taken. Pulses last exactly 1 clk.
- The locked rise and the h_total/v_total update occur in the same clk as the corresponding frame_start pulse.
- sync_err and the locked fall occur in the same clk.
- Widths: all counters are 10-bit unsigned with saturating increment; there is no wrap-around.

## Structure
- Package vga_rx_pkg holds: the state enum, default H_TOTAL/V_TOTAL constants, and the 10-bit coordinate typedef.
- Sub-module vga_sync_edge handles input sampling and produces the fall/rise strobes for h_sync, v_sync and DE. The top level holds the counters and the FSM.

## Test plan
1. Clean 640x480@800x525 stream, pclk_en every 4th clk:
   - locked rises on the 3rd v_sync fall (1st enters MEASURE, then 2 good frames).
   - h_total=800, v_total=525.
   - x sweeps 0..639, y sweeps 0..479, with 640×480 pix_valid pulses per frame.
2. While locked, stretch one line to 801 samples: sync_err pulses once, locked=0, and locked returns after 3 more v_sync falls.
3. While locked, send one 524-line frame: at that v_sync fall v_total=524, sync_err pulses, locked=0.
4. Assert reset (low) mid-line at x=300: all outputs read 0 in the same clk. After release, locking restarts from SEARCH.
5. Hold pclk_en=0 for 1000 clks mid-line: no output or state changes. The stream then resumes seamlessly with no sync_err.
6. Hold h_sync high while locked: the period counter saturates at 1023, sync_err pulses, and h_total is unchanged.
